// File: rtl/traffic_ctrl_multi.sv
// N-direction traffic-light sequencer with run-time editable phase lengths.
// Optional pedestrian green truncation: define TRAFFIC_PED_REQ_EN.
module traffic_ctrl_multi #(
  parameter int NUM_DIR    = 2,
  parameter int CNT_W      = 4,
  parameter int GREEN_DEF  = 5,
  parameter int YELLOW_DEF = 1,
  parameter int ALLRED_DEF = 1,
  parameter int PED_MIN    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick_i,
  input  logic [1:0]             mode_i,
  input  logic                   inc_i,
  input  logic                   dec_i,
  input  logic                   dflt_i,
`ifdef TRAFFIC_PED_REQ_EN
  input  logic                   ped_req_i,
`endif
  output logic [3*NUM_DIR-1:0]   light_o,
  output logic [CNT_W-1:0]       cnt_o,
  output logic [2:0]             dir_o
);

  typedef enum logic [2:0] {
    IDLE,
    GREEN,
    YELLOW,
    ALLRED,
    EDIT
  } state_t;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_GRN = 3'b010;
  localparam logic [2:0] L_YEL = 3'b011;
  localparam logic [2:0] L_WHT = 3'b000;
  localparam logic [2:0] L_IDL = 3'b001;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] GRN_DEF = CNT_W'(GREEN_DEF);
  localparam logic [CNT_W-1:0] YEL_DEF = CNT_W'(YELLOW_DEF);
  localparam logic [CNT_W-1:0] RED_DEF = CNT_W'(ALLRED_DEF);
  localparam logic [2:0]       DIR_LAST = 3'(NUM_DIR - 1);

  state_t                state_q, state_d;
  logic [2:0]            dir_q, dir_d, dir_nx;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      grn_len_q, grn_len_d;
  logic [CNT_W-1:0]      yel_len_q, yel_len_d;
  logic [CNT_W-1:0]      red_len_q, red_len_d;
  logic [1:0]            sel_q, sel_d;
  logic [3*NUM_DIR-1:0]  light_q, light_d;
  logic [CNT_W-1:0]      sel_len;
  logic                  last_tick;

`ifdef TRAFFIC_PED_REQ_EN
  localparam logic [CNT_W-1:0] PED_C = CNT_W'(PED_MIN);
  logic                  pend_q, pend_d;
`else
  logic                  unused_ped;
  assign unused_ped = (PED_MIN != 0);
`endif

  // Button edit of one length: default wins, then saturating inc/dec.
  function automatic logic [CNT_W-1:0] edit_len(
    input logic [CNT_W-1:0] cur,
    input logic [CNT_W-1:0] dv,
    input logic             df,
    input logic             in,
    input logic             dn
  );
    logic [CNT_W-1:0] r;
    r = cur;
    if (df)
      r = dv;
    else if (in)
      r = (cur == CNT_MAX) ? cur : cur + ONE;
    else if (dn)
      r = (cur <= ONE) ? ONE : cur - ONE;
    return r;
  endfunction

  // Length registers follow button pulses for the mode being edited.
  always_comb begin
    grn_len_d = grn_len_q;
    yel_len_d = yel_len_q;
    red_len_d = red_len_q;
    unique case (mode_i)
      2'b01: grn_len_d = edit_len(grn_len_q, GRN_DEF,
                                  dflt_i, inc_i, dec_i);
      2'b10: yel_len_d = edit_len(yel_len_q, YEL_DEF,
                                  dflt_i, inc_i, dec_i);
      2'b11: red_len_d = edit_len(red_len_q, RED_DEF,
                                  dflt_i, inc_i, dec_i);
      default: ;
    endcase
  end

  assign dir_nx    = (dir_q == DIR_LAST) ? 3'd0 : dir_q + 3'd1;
  assign last_tick = tick_i && (cnt_q <= ONE);
  assign sel_d     = (mode_i != 2'b00) ? mode_i : sel_q;

  // Phase sequencing, counter and pedestrian pending flag.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
`ifdef TRAFFIC_PED_REQ_EN
    pend_d  = pend_q | ped_req_i;
`endif
    if (mode_i != 2'b00) begin
      state_d = EDIT;
`ifdef TRAFFIC_PED_REQ_EN
      pend_d  = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE, EDIT: begin
          state_d = GREEN;
          dir_d   = 3'd0;
          cnt_d   = grn_len_q;
        end
        GREEN: begin
          if (last_tick) begin
            state_d = YELLOW;
            cnt_d   = yel_len_q;
`ifdef TRAFFIC_PED_REQ_EN
            pend_d  = 1'b0;
          end else if (pend_d && cnt_q > PED_C) begin
            cnt_d   = PED_C;
            pend_d  = 1'b0;
`endif
          end else if (tick_i) begin
            cnt_d   = cnt_q - ONE;
          end
        end
        YELLOW: begin
          if (last_tick) begin
            state_d = ALLRED;
            cnt_d   = red_len_q;
          end else if (tick_i) begin
            cnt_d   = cnt_q - ONE;
          end
        end
        ALLRED: begin
          if (last_tick) begin
            state_d = GREEN;
            dir_d   = dir_nx;
            cnt_d   = grn_len_q;
          end else if (tick_i) begin
            cnt_d   = cnt_q - ONE;
          end
        end
        default: begin
          state_d = IDLE;
          dir_d   = 3'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Light decode of the next state, so light_o is a plain register.
  always_comb begin
    logic [2:0] ph;
    logic [2:0] oth;
    ph  = L_RED;
    oth = L_RED;
    unique case (state_d)
      IDLE: begin
        ph  = L_IDL;
        oth = L_IDL;
      end
      GREEN:  ph = L_GRN;
      YELLOW: ph = L_YEL;
      ALLRED: ph = L_RED;
      EDIT: begin
        unique case (sel_d)
          2'b10:   ph = L_YEL;
          2'b11:   ph = L_WHT;
          default: ph = L_GRN;
        endcase
        oth = ph;
      end
      default: ;
    endcase
    light_d = '0;
    for (int k = 0; k < NUM_DIR; k++)
      light_d[3*k +: 3] = (3'(k) == dir_d) ? ph : oth;
  end

  // Single state register for the whole controller.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dir_q     <= 3'd0;
      cnt_q     <= '0;
      grn_len_q <= GRN_DEF;
      yel_len_q <= YEL_DEF;
      red_len_q <= RED_DEF;
      sel_q     <= 2'b00;
      light_q   <= {NUM_DIR{L_IDL}};
`ifdef TRAFFIC_PED_REQ_EN
      pend_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      grn_len_q <= grn_len_d;
      yel_len_q <= yel_len_d;
      red_len_q <= red_len_d;
      sel_q     <= sel_d;
      light_q   <= light_d;
`ifdef TRAFFIC_PED_REQ_EN
      pend_q    <= pend_d;
`endif
    end
  end

  // Edit mode shows the length being edited instead of the counter.
  always_comb begin
    unique case (sel_q)
      2'b10:   sel_len = yel_len_q;
      2'b11:   sel_len = red_len_q;
      default: sel_len = grn_len_q;
    endcase
  end

  assign cnt_o   = (state_q == EDIT) ? sel_len : cnt_q;
  assign dir_o   = dir_q;
  assign light_o = light_q;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Directed bench for traffic_ctrl_multi with three directions.
// Pedestrian scenario is compiled in when TRAFFIC_PED_REQ_EN is defined.
module tb_traffic_ctrl_multi;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] G = 3'b010;
  localparam logic [2:0] Y = 3'b011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_i = 1'b0;
  logic [1:0] mode_i = 2'b00;
  logic       inc_i = 1'b0;
  logic       dec_i = 1'b0;
  logic       dflt_i = 1'b0;
`ifdef TRAFFIC_PED_REQ_EN
  logic       ped_req_i = 1'b0;
`endif
  logic [8:0] light_o;
  logic [3:0] cnt_o;
  logic [2:0] dir_o;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [15:0] exp_v;

  traffic_ctrl_multi #(
    .NUM_DIR(3), .CNT_W(4), .GREEN_DEF(5),
    .YELLOW_DEF(1), .ALLRED_DEF(1), .PED_MIN(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick_i(tick_i),
    .mode_i(mode_i),
    .inc_i(inc_i),
    .dec_i(dec_i),
    .dflt_i(dflt_i),
`ifdef TRAFFIC_PED_REQ_EN
    .ped_req_i(ped_req_i),
`endif
    .light_o(light_o),
    .cnt_o(cnt_o),
    .dir_o(dir_o)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] lt(input int d, input logic [2:0] c);
    logic [8:0] v;
    v = {R, R, R};
    v[3*d +: 3] = c;
    return v;
  endfunction

  task automatic step(input logic t, input logic i,
                      input logic dn, input logic df);
    tick_i = t;
    inc_i  = i;
    dec_i  = dn;
    dflt_i = df;
    @(posedge clk);
    #1;
    tick_i = 1'b0;
    inc_i  = 1'b0;
    dec_i  = 1'b0;
    dflt_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    exp_v = {9'b001001001, 4'd0, 3'd0};
    total_cnt++;
    if ({light_o, cnt_o, dir_o} !== exp_v)
      $display("FAIL reset: got %h want %h", {light_o, cnt_o, dir_o}, exp_v);
    else pass_cnt++;
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_v = {lt(0, G), 4'd5, 3'd0};
    total_cnt++;
    if ({light_o, cnt_o, dir_o} !== exp_v)
      $display("FAIL idle_to_green: got %h want %h", {light_o, cnt_o, dir_o}, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_run;
    for (int d = 0; d < 3; d++) begin
      exp_v = {lt(d, G), 4'd5, 3'(d)};
      total_cnt++;
      if ({light_o, cnt_o, dir_o} !== exp_v)
        $display("FAIL run_green_d%0d: got %h want %h", d, {light_o, cnt_o, dir_o}, exp_v);
      else pass_cnt++;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if ({light_o, cnt_o, dir_o} !== exp_v)
        $display("FAIL run_notick_d%0d: got %h want %h", d, {light_o, cnt_o, dir_o}, exp_v);
      else pass_cnt++;
      for (int c = 4; c >= 1; c--) begin
        step(1'b1, 1'b0, 1'b0, 1'b0);
        exp_v = {lt(d, G), 4'(c), 3'(d)};
        total_cnt++;
        if ({light_o, cnt_o, dir_o} !== exp_v)
          $display("FAIL run_cnt_d%0d_c%0d: got %h want %h", d, c, {light_o, cnt_o, dir_o}, exp_v);
        else pass_cnt++;
      end
      step(1'b1, 1'b0, 1'b0, 1'b0);
      exp_v = {lt(d, Y), 4'd1, 3'(d)};
      total_cnt++;
      if ({light_o, cnt_o, dir_o} !== exp_v)
        $display("FAIL run_yellow_d%0d: got %h want %h", d, {light_o, cnt_o, dir_o}, exp_v);
      else pass_cnt++;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      exp_v = {lt(d, R), 4'd1, 3'(d)};
      total_cnt++;
      if ({light_o, cnt_o, dir_o} !== exp_v)
        $display("FAIL run_allred_d%0d: got %h want %h", d, {light_o, cnt_o, dir_o}, exp_v);
      else pass_cnt++;
      step(1'b1, 1'b0, 1'b0, 1'b0);
    end
    exp_v = {lt(0, G), 4'd5, 3'd0};
    total_cnt++;
    if ({light_o, cnt_o, dir_o} !== exp_v)
      $display("FAIL run_wrap: got %h want %h", {light_o, cnt_o, dir_o}, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_edit_green;
    mode_i = 2'b01;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    exp_v = {9'b010010010, 4'd5, 3'd0};
    total_cnt++;
    if ({light_o, cnt_o, dir_o} !== exp_v)
      $display("FAIL edit_green_enter: got %h want %h", {light_o, cnt_o, dir_o}, exp_v);
    else pass_cnt++;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (cnt_o !== 4'd6)
      $display("FAIL edit_green_inc1: got %0d want 6", cnt_o);
    else pass_cnt++;
    for (int i = 0; i < 11; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    exp_v = {9'b010010010, 4'd15, 3'd0};
    total_cnt++;
    if ({light_o, cnt_o, dir_o} !== exp_v)
      $display("FAIL edit_green_sat: got %h want %h", {light_o, cnt_o, dir_o}, exp_v);
    else pass_cnt++;
    mode_i = 2'b00;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    exp_v = {lt(0, G), 4'd15, 3'd0};
    total_cnt++;
    if ({light_o, cnt_o, dir_o} !== exp_v)
      $display("FAIL edit_green_return: got %h want %h", {light_o, cnt_o, dir_o}, exp_v);
    else pass_cnt++;
    mode_i = 2'b01;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (cnt_o !== 4'd5)
      $display("FAIL edit_green_dflt: got %0d want 5", cnt_o);
    else pass_cnt++;
    mode_i = 2'b00;
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_edit_yellow;
    mode_i = 2'b10;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    exp_v = {9'b011011011, 4'd1, 3'd0};
    total_cnt++;
    if ({light_o, cnt_o, dir_o} !== exp_v)
      $display("FAIL edit_yel_enter: got %h want %h", {light_o, cnt_o, dir_o}, exp_v);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    total_cnt++;
    if (cnt_o !== 4'd1)
      $display("FAIL edit_yel_dec_sat: got %0d want 1", cnt_o);
    else pass_cnt++;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (cnt_o !== 4'd2)
      $display("FAIL edit_yel_inc: got %0d want 2", cnt_o);
    else pass_cnt++;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    total_cnt++;
    if (cnt_o !== 4'd1)
      $display("FAIL edit_yel_dflt_prio: got %0d want 1", cnt_o);
    else pass_cnt++;
    mode_i = 2'b00;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    exp_v = {lt(0, G), 4'd5, 3'd0};
    total_cnt++;
    if ({light_o, cnt_o, dir_o} !== exp_v)
      $display("FAIL edit_yel_return: got %h want %h", {light_o, cnt_o, dir_o}, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_min_green;
    mode_i = 2'b01;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    total_cnt++;
    if (cnt_o !== 4'd1)
      $display("FAIL min_green_len: got %0d want 1", cnt_o);
    else pass_cnt++;
    mode_i = 2'b00;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    exp_v = {lt(0, G), 4'd1, 3'd0};
    total_cnt++;
    if ({light_o, cnt_o, dir_o} !== exp_v)
      $display("FAIL min_green_hold: got %h want %h", {light_o, cnt_o, dir_o}, exp_v);
    else pass_cnt++;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_v = {lt(0, Y), 4'd1, 3'd0};
    total_cnt++;
    if ({light_o, cnt_o, dir_o} !== exp_v)
      $display("FAIL min_green_one_tick: got %h want %h", {light_o, cnt_o, dir_o}, exp_v);
    else pass_cnt++;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_v = {lt(1, G), 4'd1, 3'd1};
    total_cnt++;
    if ({light_o, cnt_o, dir_o} !== exp_v)
      $display("FAIL min_green_d1: got %h want %h", {light_o, cnt_o, dir_o}, exp_v);
    else pass_cnt++;
    mode_i = 2'b01;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    mode_i = 2'b00;
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_allred_edit_mid_yellow;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_v = {lt(1, Y), 4'd1, 3'd1};
    total_cnt++;
    if ({light_o, cnt_o, dir_o} !== exp_v)
      $display("FAIL mid_yel_reach: got %h want %h", {light_o, cnt_o, dir_o}, exp_v);
    else pass_cnt++;
    mode_i = 2'b11;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    exp_v = {9'b000000000, 4'd1, 3'd1};
    total_cnt++;
    if ({light_o, cnt_o, dir_o} !== exp_v)
      $display("FAIL edit_red_enter: got %h want %h", {light_o, cnt_o, dir_o}, exp_v);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if ({light_o, cnt_o, dir_o} !== exp_v)
      $display("FAIL edit_red_ticks: got %h want %h", {light_o, cnt_o, dir_o}, exp_v);
    else pass_cnt++;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (cnt_o !== 4'd2)
      $display("FAIL edit_red_inc: got %0d want 2", cnt_o);
    else pass_cnt++;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (cnt_o !== 4'd1)
      $display("FAIL edit_red_dflt: got %0d want 1", cnt_o);
    else pass_cnt++;
    mode_i = 2'b00;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_v = {lt(0, G), 4'd5, 3'd0};
    total_cnt++;
    if ({light_o, cnt_o, dir_o} !== exp_v)
      $display("FAIL edit_red_return: got %h want %h", {light_o, cnt_o, dir_o}, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_edit;
    mode_i = 2'b01;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (cnt_o !== 4'd6)
      $display("FAIL rst_edit_pre: got %0d want 6", cnt_o);
    else pass_cnt++;
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    exp_v = {9'b001001001, 4'd0, 3'd0};
    total_cnt++;
    if ({light_o, cnt_o, dir_o} !== exp_v)
      $display("FAIL rst_edit_reset: got %h want %h", {light_o, cnt_o, dir_o}, exp_v);
    else pass_cnt++;
    rst = 1'b0;
    mode_i = 2'b00;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    exp_v = {lt(0, G), 4'd5, 3'd0};
    total_cnt++;
    if ({light_o, cnt_o, dir_o} !== exp_v)
      $display("FAIL rst_edit_defaults: got %h want %h", {light_o, cnt_o, dir_o}, exp_v);
    else pass_cnt++;
  endtask

`ifdef TRAFFIC_PED_REQ_EN
  task automatic test_ped;
    ped_req_i = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    ped_req_i = 1'b0;
    exp_v = {lt(0, G), 4'd2, 3'd0};
    total_cnt++;
    if ({light_o, cnt_o, dir_o} !== exp_v)
      $display("FAIL ped_trunc: got %h want %h", {light_o, cnt_o, dir_o}, exp_v);
    else pass_cnt++;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_v = {lt(0, Y), 4'd1, 3'd0};
    total_cnt++;
    if ({light_o, cnt_o, dir_o} !== exp_v)
      $display("FAIL ped_green_end: got %h want %h", {light_o, cnt_o, dir_o}, exp_v);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    ped_req_i = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    ped_req_i = 1'b0;
    exp_v = {lt(1, G), 4'd2, 3'd1};
    total_cnt++;
    if ({light_o, cnt_o, dir_o} !== exp_v)
      $display("FAIL ped_at_min: got %h want %h", {light_o, cnt_o, dir_o}, exp_v);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    exp_v = {lt(2, G), 4'd5, 3'd2};
    total_cnt++;
    if ({light_o, cnt_o, dir_o} !== exp_v)
      $display("FAIL ped_cleared: got %h want %h", {light_o, cnt_o, dir_o}, exp_v);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_run();
    test_edit_green();
    test_edit_yellow();
    test_min_green();
    test_allred_edit_mid_yellow();
    test_reset_mid_edit();
`ifdef TRAFFIC_PED_REQ_EN
    test_ped();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl_multi.md
# traffic_ctrl_multi

Parametrised N-direction traffic-light sequencer with run-time programmable green/yellow/all-red durations. It is the multi-direction successor of the two-way controller: it cycles any number of directions, takes a 1 Hz tick enable from the clock divider, and takes already-debounced single-cycle button pulses from the debouncers. It sits between the divider/debouncers and the board LEDs.

## Interface
- NUM_DIR, 2, number of directions served in round-robin (2..8)
- CNT_W, 4, width of duration registers and counter
- GREEN_DEF, 5, reset/default green length in ticks
- YELLOW_DEF, 1, reset/default yellow length
- ALLRED_DEF, 1, reset/default all-red length
- PED_MIN, 2, truncated green length on pedestrian request (macro only)

- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- tick_i  in  1  one-cycle time-base enable (1 Hz)
- mode_i  in  2  00 run, 01 edit green, 10 edit yellow, 11 edit all-red
- inc_i / dec_i / dflt_i  in  1 each  debounced single-cycle pulses
- ped_req_i  in  1  pedestrian request, level (present only with macro)
- light_o  out  3*NUM_DIR  per-direction code, direction k at [3k+2:3k]
- cnt_o  out  CNT_W  remaining count (run) or edited length (edit)
- dir_o  out  3  active direction index

## Operation
- Light codes: 100 red, 010 green, 011 yellow, 000 white, 001 idle.
- FSM states: IDLE, GREEN, YELLOW, ALLRED, EDIT; direction index d.
- IDLE -> GREEN(d=0) on first clock after reset, cnt loaded with green length.
- Run sequence per d: GREEN -> YELLOW -> ALLRED -> GREEN(d+1 mod NUM_DIR).
- Phase length L: loaded into cnt on entry; on tick, if cnt<=1 advance and load next length, else cnt-=1. Phase lasts max(L,1) ticks; L=0 behaves as 1.
- Lights in run: direction d shows phase colour (ALLRED: 100); all others 100.
- mode_i!=00 -> EDIT on next edge from any state; counter frozen, ticks ignored.
- EDIT lights: all directions 010 / 011 / 000 for green / yellow / all-red edit.
- Edit of selected length, priority dflt > inc > dec: dflt reloads the parameter default; inc saturates at 2^CNT_W-1; dec saturates at 1.
- EDIT -> mode_i==00 -> GREEN(d=0) with fresh green load (edits take effect).
- Lengths persist across mode changes; only rst restores defaults.

## Timing
- Reset: state IDLE, d=0, cnt=0, lengths = defaults, light_o all 001, cnt_o 0, dir_o 0, pending 0.
- light_o/dir_o decode registered state; cnt_o is the counter register (edit mode: selected length register); all change one edge after the causing input.
- Button pulse -> length register updated at that edge; cnt_o shows it next cycle.
- Ticks sampled only in run states; tick in IDLE is ignored.
- Mode change mid-phase: phase abandoned, no partial completion.
- rst mid-phase or mid-edit wins over all inputs, including pending edits.

## Configuration
- TRAFFIC_PED_REQ_EN defined: ped_req_i present; any high sample sets pending. In GREEN with pending and cnt>PED_MIN, cnt loads PED_MIN (no tick needed) and pending clears; pending also clears when any GREEN ends. Tick-driven advance takes precedence over truncation in the same cycle. Pending ignored and cleared in EDIT.
- Undefined: no port, no pending flag, green always runs full length.

## Test plan
- Reset, NUM_DIR=3, defaults -> sequence G(5)Y(1)R(1) for d=0,1,2 then d=0 again; 21 ticks per cycle; other directions 100.
- mode_i=01, 12 inc pulses from 5 -> green saturates at 15; mode 00 -> GREEN d=0 cnt_o 15.
- mode_i=10, 3 dec pulses from 1 -> stays 1; dflt with inc same cycle -> 1 (dflt wins).
- Green length 0 programmed via dflt+edits impossible below 1; force L=1 -> GREEN lasts exactly 1 tick.
- mode_i=11 mid-YELLOW d=1 -> lights 000, cnt_o=1, ticks ignored; return -> GREEN d=0.
- With TRAFFIC_PED_REQ_EN: ped_req_i pulse at GREEN cnt=5 -> cnt_o 2 next edge, GREEN ends after 2 more ticks; pulse at cnt=2 -> no change.
